// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: ECP5 EHXPLLL dynamic phase-step sequencer (req handshake in, PHASESEL/DIR/STEP/LOADREG out); PLL_PHASELOADREG_EN adds the PHASELOADREG commit pulse
module pll_phase_ctrl #(
  parameter int SETUP_CYC    = 4,
  parameter int PULSE_CYC    = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [4:0] req_steps,
  input  logic       pll_locked,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       phaseloadreg,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic       locked_sync
);
  localparam int CMAX = (SETUP_CYC + PULSE_CYC > LOCK_TIMEOUT) ? SETUP_CYC + PULSE_CYC : LOCK_TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
`ifdef PLL_PHASELOADREG_EN
    LOAD,
`endif
    LOCKWAIT,
    DONE
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d, sync_q, sync_d;
  logic dir_q, dir_d, to_q, to_d;
  logic [4:0] steps_q, steps_d;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      dir_q   <= 1'b0;
      steps_q <= '0;
      to_q    <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      steps_q <= steps_d;
      to_q    <= to_d;
      sync_q  <= sync_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    sel_d   = sel_q;
    dir_d   = dir_q;
    steps_d = steps_q;
    to_d    = to_q;
    sync_d  = {sync_q[0], pll_locked};
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid && req_ready) begin
          sel_d   = req_sel;
          dir_d   = req_dir;
          steps_d = req_steps;
          to_d    = 1'b0;
          state_d = (req_steps == 5'd0) ? DONE : SETUP;
        end
      end
      SETUP: if (cnt_q == CW'(SETUP_CYC - 1)) begin
        cnt_d   = '0;
        state_d = PULSE;
      end
      PULSE: if (cnt_q == CW'(PULSE_CYC - 1)) begin
        cnt_d   = '0;
        state_d = HOLD;
      end
      HOLD: if (cnt_q == CW'(SETUP_CYC - 1)) begin
        cnt_d   = '0;
        steps_d = steps_q - 1'b1;
`ifdef PLL_PHASELOADREG_EN
        state_d = (steps_q == 5'd1) ? LOAD : PULSE;
`else
        state_d = (steps_q == 5'd1) ? LOCKWAIT : PULSE;
`endif
      end
`ifdef PLL_PHASELOADREG_EN
      LOAD: if (cnt_q == CW'(PULSE_CYC + SETUP_CYC - 1)) begin
        cnt_d   = '0;
        state_d = LOCKWAIT;
      end
`endif
      LOCKWAIT: if (locked_sync) begin
        to_d    = 1'b0;
        state_d = DONE;
      end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
        to_d    = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign locked_sync = sync_q[1];
  assign req_ready   = (state_q == IDLE) && locked_sync;
  assign busy        = state_q != IDLE;
  assign done        = state_q == DONE;
  assign timeout     = done && to_q;
  assign phasestep   = state_q != PULSE;
  assign phasesel    = sel_q;
  assign phasedir    = dir_q;
`ifdef PLL_PHASELOADREG_EN
  assign phaseloadreg = !((state_q == LOAD) && (cnt_q < CW'(PULSE_CYC)));
`else
  assign phaseloadreg = 1'b1;
`endif
endmodule

// File: doc/pll_phase_ctrl.md
# pll_phase_ctrl

Sequencer for the dynamic phase-shift port of the board's ECP5 EHXPLLL clock generator. It accepts phase-step requests from a requester, such as a video or SDRAM calibration routine. It drives PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG with the required setup, pulse and hold spacing, then waits for the PLL to re-lock and reports completion or timeout. It runs on the PLL's reference-side system clock and sits between the PLL wrapper and the calibration logic.

## Interface
- SETUP_CYC, default 4: cycles PHASESEL/PHASEDIR are stable before and after each PHASESTEP pulse (≥1).
- PULSE_CYC, default 4: cycles PHASESTEP is held low per step (≥1).
- LOCK_TIMEOUT, default 1024: max cycles waited for synchronized lock after the last step (≥2).
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_sel  in  2  output select: 0=CLKOS, 1=CLKOS2, 2=CLKOS3, 3=CLKOP.
- req_dir  in  1  1=lead, 0=lag (passed to PHASEDIR).
- req_steps  in  5  number of phase steps, 0–31.
- pll_locked  in  1  PLL LOCK, asynchronous to clock.
- phasesel  out  2  to PLL PHASESEL[1:0].
- phasedir  out  1  to PLL PHASEDIR.
- phasestep  out  1  to PLL PHASESTEP, idle high.
- phaseloadreg  out  1  to PLL PHASELOADREG, idle high.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  valid with done: lock not regained.
- locked_sync  out  1  two-flop synchronized pll_locked.

## Operation
- pll_locked passes through a two-flop synchronizer; locked_sync is its output.
- States: IDLE, SETUP, PULSE, HOLD, LOAD (macro only), LOCKWAIT, DONE.
- IDLE:
  - req_ready = locked_sync.
  - On accept, latch sel/dir/steps, drive phasesel/phasedir from the latched values, and go to SETUP.
  - If steps==0, go straight to DONE: no PHASESTEP pulses, timeout=0.
- SETUP: wait SETUP_CYC cycles, then PULSE.
- PULSE: phasestep=0 for PULSE_CYC cycles, then HOLD.
- HOLD:
  - Wait SETUP_CYC cycles with phasestep=1.
  - Decrement the remaining-step count.
  - If nonzero, go to PULSE. Setup time is already covered by HOLD.
  - Otherwise go to LOAD (macro) or LOCKWAIT.
- LOCKWAIT:
  - Counter starts at 0.
  - locked_sync=1 → DONE with timeout=0.
  - Counter reaches LOCK_TIMEOUT-1 without lock → DONE with timeout=1.
- DONE: done=1 for one cycle, timeout valid in the same cycle, then return to IDLE.
- phasesel/phasedir hold the latched values from accept until the next accept; they never change while phasestep=0.
- busy=1 in every state except IDLE.
- req_valid during busy is ignored; it is not queued.
- Lock loss outside LOCKWAIT has no effect on the running sequence. It only blocks the next accept via req_ready.

## Timing
- Reset values: phasesel=0, phasedir=0, phasestep=1, phaseloadreg=1, req_ready=0, busy=0, done=0, timeout=0, locked_sync=0, state=IDLE.
- Reset asserted mid-sequence returns every output to its reset value asynchronously. phasestep=1 immediately terminates any pulse.
- locked_sync lags pll_locked by 2 cycles.
- Accept at cycle 0: SETUP spans cycles 1..SETUP_CYC.
- First step: phasestep is low for cycles SETUP_CYC+1 .. SETUP_CYC+PULSE_CYC.
- Each step period is PULSE_CYC+SETUP_CYC cycles.
- Cycles from accept to LOCKWAIT entry, for N>0 steps, without macro: SETUP_CYC + N·(PULSE_CYC+SETUP_CYC) + 1.
- LOCKWAIT with lock already high: done asserts 1 cycle after LOCKWAIT entry.
- steps==0: done asserts the cycle after accept.
- req_ready is deasserted from the cycle after accept until the cycle after done.

## Configuration
- PLL_PHASELOADREG_EN defined:
  - After the last HOLD, the LOAD state drives phaseloadreg=0 for PULSE_CYC cycles, then phaseloadreg=1 for SETUP_CYC cycles, then LOCKWAIT.
  - This commits the stepped phase into the PLL's static phase register.
- Undefined: the LOAD state does not exist and phaseloadreg is constant 1.

## Test plan
- Reset with pll_locked=1; release reset → locked_sync=1 by cycle 2, req_ready=1, phasestep=1, phaseloadreg=1.
- Request sel=1, dir=1, steps=3, SETUP=PULSE=4, lock held high:
  - Exactly 3 phasestep low pulses of 4 cycles, first starting cycle 5, spaced 8 cycles apart.
  - phasesel=1 and phasedir=1 stable throughout.
  - done at cycle 30, timeout=0.
- steps=0 → no phasestep activity; done the cycle after accept; timeout=0.
- Drop pll_locked during steps=1 and keep it low → done with timeout=1 exactly LOCK_TIMEOUT cycles after LOCKWAIT entry.
  - Repeat with lock restored 20 cycles after LOCKWAIT entry → done with timeout=0 within 3 cycles of lock return.
- Assert reset_n=0 while phasestep=0 → phasestep=1, busy=0 asynchronously. After release, a new request runs normally.
- With PLL_PHASELOADREG_EN, steps=2 → one 4-cycle phaseloadreg low pulse after the second HOLD, before done.
  - Without the macro, phaseloadreg never leaves 1.
